// File: rtl/vid_timing_monitor.sv
// Video raster timing monitor: measures hs/vs/de timing per line and per frame,
// checks it against the configured raster and runs a lock FSM with a vs watchdog.
module vid_timing_monitor #(
    parameter int H_WIDTH  = 1920,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2,
    parameter int TIMEOUT  = 4950000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        de_i,
    output logic [11:0] h_active_o,
    output logic [11:0] h_total_o,
    output logic [11:0] v_active_o,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic        locked_o,
    output logic        timeout_o
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, HOLD} state_t;

    state_t          state, state_nxt;
    logic [7:0]      n, n_nxt;
    logic            locked_nxt;

    logic            hs_r, vs_r, de_r, hs_d, vs_d, de_d;
    logic [11:0]     h_cnt, de_cnt, v_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            armed, h_seen, line_bad;

    logic            hs_rise, vs_rise, de_fall;
    logic [11:0]     h_meas, de_inc, v_inc, v_cur;
    logic            hs_meas, hs_bad, de_bad, frame_eval, frame_ok_nxt, timeout_hit;

    assign hs_rise = hs_r & ~hs_d;
    assign vs_rise = vs_r & ~vs_d;
    assign de_fall = ~de_r & de_d;

    assign h_meas  = (h_cnt == 12'hFFF) ? h_cnt : h_cnt + 12'd1;
    assign de_inc  = (de_cnt == 12'hFFF) ? de_cnt : de_cnt + 12'd1;
    assign v_inc   = (v_cnt == 12'hFFF) ? v_cnt : v_cnt + 12'd1;

    // The first hs rise after arming has no valid reference, so it only restarts h_cnt.
    assign hs_meas = hs_rise & armed & h_seen;
    assign hs_bad  = hs_meas && (h_meas != 12'(H_TOTAL));
    assign de_bad  = de_fall && (de_cnt != 12'(H_WIDTH));

    // A line ending in the same cycle as vs rise belongs to the frame being closed.
    assign v_cur        = de_fall ? v_inc : v_cnt;
    assign frame_eval   = vs_rise & armed;
    assign frame_ok_nxt = !(line_bad | hs_bad | de_bad) && (v_cur == 12'(V_HEIGHT));
    assign timeout_hit  = (wd_cnt == WD_W'(TIMEOUT - 1)) & ~vs_rise;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {hs_r, vs_r, de_r, hs_d, vs_d, de_d} <= '0;
            h_cnt        <= '0;
            de_cnt       <= '0;
            v_cnt        <= '0;
            wd_cnt       <= '0;
            armed        <= 1'b0;
            h_seen       <= 1'b0;
            line_bad     <= 1'b0;
            h_active_o   <= '0;
            h_total_o    <= '0;
            v_active_o   <= '0;
            frame_done_o <= 1'b0;
            frame_ok_o   <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            {hs_r, vs_r, de_r} <= {hs_i, vs_i, de_i};
            {hs_d, vs_d, de_d} <= {hs_r, vs_r, de_r};
            frame_done_o <= 1'b0;
            timeout_o    <= 1'b0;

            h_cnt <= hs_rise ? 12'd0 : h_meas;
            if (hs_meas)
                h_total_o <= h_meas;
            if (!armed)
                h_seen <= 1'b0;
            else if (hs_rise)
                h_seen <= 1'b1;

            de_cnt <= de_r ? de_inc : 12'd0;
            if (de_fall)
                h_active_o <= de_cnt;

            if (vs_rise) begin
                v_cnt    <= '0;
                line_bad <= 1'b0;
                armed    <= 1'b1;
                if (armed) begin
                    frame_ok_o   <= frame_ok_nxt;
                    v_active_o   <= v_cur;
                    frame_done_o <= 1'b1;
                end
            end else begin
                if (de_fall)
                    v_cnt <= v_inc;
                if (hs_bad | de_bad)
                    line_bad <= 1'b1;
            end

            if (vs_rise) begin
                wd_cnt <= '0;
            end else if (timeout_hit) begin
                wd_cnt    <= '0;
                timeout_o <= 1'b1;
                armed     <= 1'b0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= UNLOCKED;
            n        <= '0;
            locked_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            n        <= n_nxt;
            locked_o <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        if (timeout_hit) begin
            state_nxt = UNLOCKED;
            n_nxt     = '0;
        end else if (frame_eval) begin
            case (state)
                UNLOCKED: if (frame_ok_nxt) begin
                    state_nxt = (LOCK_N <= 1) ? LOCKED : ACQUIRE;
                    n_nxt     = (LOCK_N <= 1) ? 8'd0 : 8'd1;
                end
                ACQUIRE: if (!frame_ok_nxt) begin
                    state_nxt = UNLOCKED;
                    n_nxt     = '0;
                end else if (int'(n) + 1 >= LOCK_N) begin
                    state_nxt = LOCKED;
                    n_nxt     = '0;
                end else begin
                    n_nxt = n + 8'd1;
                end
                LOCKED: if (!frame_ok_nxt) begin
                    state_nxt = (UNLOCK_N <= 1) ? UNLOCKED : HOLD;
                    n_nxt     = (UNLOCK_N <= 1) ? 8'd0 : 8'd1;
                end
                HOLD: if (frame_ok_nxt) begin
                    state_nxt = LOCKED;
                    n_nxt     = '0;
                end else if (int'(n) + 1 >= UNLOCK_N) begin
                    state_nxt = UNLOCKED;
                    n_nxt     = '0;
                end else begin
                    n_nxt = n + 8'd1;
                end
                default: begin
                    state_nxt = UNLOCKED;
                    n_nxt     = '0;
                end
            endcase
        end
    end

    // Registered lock flag follows the next state so it moves with frame_done_o.
    always_comb begin
        locked_nxt = (state_nxt == LOCKED) || (state_nxt == HOLD);
    end
endmodule

// File: tb/tb_vid_timing_monitor.sv
// Directed bench for vid_timing_monitor with a reduced raster (16x8 active, 24 clk lines, 10 lines/frame).
module tb_vid_timing_monitor;
    logic        clk = 1'b0;
    logic        rst, hs, vs, de;
    logic [11:0] h_active_o, h_total_o, v_active_o;
    logic        frame_done_o, frame_ok_o, locked_o, timeout_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         fd_cnt = 0, to_cnt = 0, fd_cyc = 0, to_cyc = 0;
    logic [7:0] ok_hist = '0, lock_hist = '0;
    logic [11:0] v_last = '0;

    vid_timing_monitor #(
        .H_WIDTH(16), .H_TOTAL(24), .V_HEIGHT(8),
        .LOCK_N(4), .UNLOCK_N(2), .TIMEOUT(1000)
    ) dut (
        .clk_i(clk), .rst_i(rst), .hs_i(hs), .vs_i(vs), .de_i(de),
        .h_active_o(h_active_o), .h_total_o(h_total_o), .v_active_o(v_active_o),
        .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o),
        .locked_o(locked_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done_o) begin
            fd_cnt    <= fd_cnt + 1;
            fd_cyc    <= cyc;
            ok_hist   <= {ok_hist[6:0], frame_ok_o};
            lock_hist <= {lock_hist[6:0], locked_o};
            v_last    <= v_active_o;
        end
        if (timeout_o) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
    end

    task automatic line(input int de_start, input int de_len, input int tot, input bit v);
        for (int c = 0; c < tot; c++) begin
            @(posedge clk); #1;
            hs = (c < 2);
            vs = v;
            de = (c >= de_start) && (c < de_start + de_len);
        end
    endtask

    // n_de active lines at the bottom of a 10-line frame; last line optionally short
    task automatic frame(input int n_de, input int short_len);
        for (int l = 0; l < 10; l++) begin
            int len;
            len = 0;
            if (l >= 10 - n_de) len = (l == 9 && short_len != 0) ? short_len : 16;
            line(4, len, 24, l == 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            hs = 1'b0; vs = 1'b0; de = 1'b0;
        end
    endtask

    task automatic run_lock_seq(input string tag);
        int fd0;
        fd0 = fd_cnt;
        for (int f = 0; f < 6; f++) frame(8, 0);
        total++; if (fd_cnt - fd0 !== 5) begin bad++; $display("FAIL %s fd_count got=%0d exp=5", tag, fd_cnt - fd0); end
        total++; if (ok_hist[4:0] !== 5'b11111) begin bad++; $display("FAIL %s ok_hist got=%b exp=11111", tag, ok_hist[4:0]); end
        total++; if (lock_hist[4:0] !== 5'b00011) begin bad++; $display("FAIL %s lock_hist got=%b exp=00011", tag, lock_hist[4:0]); end
        total++; if (h_active_o !== 12'd16) begin bad++; $display("FAIL %s h_active got=%0d exp=16", tag, h_active_o); end
        total++; if (h_total_o !== 12'd24) begin bad++; $display("FAIL %s h_total got=%0d exp=24", tag, h_total_o); end
        total++; if (v_last !== 12'd8) begin bad++; $display("FAIL %s v_active got=%0d exp=8", tag, v_last); end
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL %s locked got=%b exp=1", tag, locked_o); end
    endtask

    task automatic test_reset;
        rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({h_active_o, h_total_o, v_active_o} !== 36'd0) begin bad++; $display("FAIL reset_counts got=%h exp=0", {h_active_o, h_total_o, v_active_o}); end
        total++; if ({frame_done_o, frame_ok_o, locked_o, timeout_o} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {frame_done_o, frame_ok_o, locked_o, timeout_o}); end
        rst = 1'b0;
    endtask

    task automatic test_clean;
        run_lock_seq("clean");
    endtask

    task automatic test_short_line;
        frame(8, 15);
        total++; if (h_active_o !== 12'd15) begin bad++; $display("FAIL short_h_active got=%0d exp=15", h_active_o); end
        frame(8, 0);
        total++; if (ok_hist[0] !== 1'b0) begin bad++; $display("FAIL short_frame_ok got=%b exp=0", ok_hist[0]); end
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL short_hold_locked got=%b exp=1", locked_o); end
        frame(8, 0);
        total++; if (ok_hist[0] !== 1'b1) begin bad++; $display("FAIL short_recover_ok got=%b exp=1", ok_hist[0]); end
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL short_recover_locked got=%b exp=1", locked_o); end
    endtask

    task automatic test_missing_lines;
        frame(8, 0);
        frame(7, 0);
        frame(7, 0);
        total++; if (v_last !== 12'd7) begin bad++; $display("FAIL miss1_v_active got=%0d exp=7", v_last); end
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL miss1_locked got=%b exp=1", locked_o); end
        frame(8, 0);
        total++; if (v_last !== 12'd7) begin bad++; $display("FAIL miss2_v_active got=%0d exp=7", v_last); end
        total++; if (ok_hist[1:0] !== 2'b00) begin bad++; $display("FAIL miss2_ok got=%b exp=00", ok_hist[1:0]); end
        total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL miss2_locked got=%b exp=0", locked_o); end
    endtask

    task automatic test_timeout;
        int to0;
        for (int f = 0; f < 4; f++) frame(8, 0);
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL relock_before_to got=%b exp=1", locked_o); end
        to0 = to_cnt;
        idle(1100);
        total++; if (to_cnt - to0 !== 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", to_cnt - to0); end
        total++; if (to_cyc - fd_cyc !== 1000) begin bad++; $display("FAIL to_delay got=%0d exp=1000", to_cyc - fd_cyc); end
        total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL to_locked got=%b exp=0", locked_o); end
        run_lock_seq("resume");
    endtask

    task automatic test_align_and_htotal;
        for (int l = 0; l < 10; l++)
            line((l == 9) ? 8 : 4, (l >= 2) ? 16 : 0, 24, l == 0);
        frame(8, 0);
        total++; if (v_last !== 12'd8) begin bad++; $display("FAIL align_v_active got=%0d exp=8", v_last); end
        total++; if (ok_hist[0] !== 1'b1) begin bad++; $display("FAIL align_ok got=%b exp=1", ok_hist[0]); end
        for (int l = 0; l < 10; l++) begin
            line(4, (l >= 2) ? 16 : 0, (l == 5) ? 25 : 24, l == 0);
            if (l == 6) begin
                total++; if (h_total_o !== 12'd25) begin bad++; $display("FAIL long_h_total got=%0d exp=25", h_total_o); end
            end
        end
        frame(8, 0);
        total++; if (ok_hist[0] !== 1'b0) begin bad++; $display("FAIL long_frame_ok got=%b exp=0", ok_hist[0]); end
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL long_hold_locked got=%b exp=1", locked_o); end
        frame(8, 0);
        total++; if (ok_hist[0] !== 1'b1) begin bad++; $display("FAIL long_recover_ok got=%b exp=1", ok_hist[0]); end
    endtask

    task automatic test_reset_midframe;
        for (int l = 0; l < 5; l++) line(4, (l >= 2) ? 16 : 0, 24, l == 0);
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL pre_rst_locked got=%b exp=1", locked_o); end
        #2 rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
        #1;
        total++; if ({h_active_o, h_total_o, v_active_o} !== 36'd0) begin bad++; $display("FAIL async_rst_counts got=%h exp=0", {h_active_o, h_total_o, v_active_o}); end
        total++; if ({frame_done_o, frame_ok_o, locked_o, timeout_o} !== 4'b0) begin bad++; $display("FAIL async_rst_flags got=%b exp=0000", {frame_done_o, frame_ok_o, locked_o, timeout_o}); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_lock_seq("post_rst");
        total++; if (to_cnt !== 1) begin bad++; $display("FAIL stray_timeouts got=%0d exp=1", to_cnt); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_short_line();
        test_missing_lines();
        test_timeout();
        test_align_and_htotal();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
